// File: rtl/smart_house_pkg.sv
// Shared constants for the house load scheduler: load indices, default costs and timing.
package smart_house_pkg;

  localparam int N_LOADS_DEF  = 5;
  localparam int COST_W_DEF   = 4;
  localparam int BUDGET_DEF   = 8;
  localparam int MIN_ON_DEF   = 16;
  localparam int COOLDOWN_DEF = 8;

  localparam int LOAD_MUSIC   = 0;
  localparam int LOAD_CURTAIN = 1;
  localparam int LOAD_LIGHT   = 2;
  localparam int LOAD_COOLER  = 3;
  localparam int LOAD_HEATER  = 4;

  // Packed default costs, slice i = load i: music 1, curtain 2, light 1, cooler 5, heater 6.
  localparam logic [N_LOADS_DEF*COST_W_DEF-1:0] DEF_COSTS = {4'd6, 4'd5, 4'd1, 4'd2, 4'd1};

endpackage

// File: rtl/load_slot.sv
// Per-load state: grant flag, minimum on-time and cool-down down-counters, captured cost.
module load_slot #(
  parameter int COST_W   = 4,
  parameter int MIN_ON   = 16,
  parameter int COOLDOWN = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              grant_issue_i,
  input  logic [COST_W-1:0] cost_i,
  input  logic              req_i,
  output logic              granted_o,
  output logic              release_o,
  output logic              grantable_o,
  output logic [COST_W-1:0] cap_cost_o
);

  localparam int ON_W  = $clog2(MIN_ON + 1);
  localparam int OFF_W = $clog2(COOLDOWN + 1);

  logic              granted_q, granted_d;
  logic [ON_W-1:0]   on_cnt_q, on_cnt_d;
  logic [OFF_W-1:0]  off_cnt_q, off_cnt_d;
  logic [COST_W-1:0] cap_q, cap_d;
  logic              release_w;

  assign release_w = granted_q && (on_cnt_q == '0) && !req_i;

  always_comb begin
    granted_d = granted_q;
    on_cnt_d  = on_cnt_q;
    off_cnt_d = off_cnt_q;
    cap_d     = cap_q;
    if (grant_issue_i) begin
      granted_d = 1'b1;
      cap_d     = cost_i;
      on_cnt_d  = ON_W'(MIN_ON);
    end else if (granted_q) begin
      if (on_cnt_q != '0) begin
        on_cnt_d = on_cnt_q - ON_W'(1);
      end else if (release_w) begin
        granted_d = 1'b0;
        off_cnt_d = OFF_W'(COOLDOWN);
      end
    end else if (off_cnt_q != '0) begin
      off_cnt_d = off_cnt_q - OFF_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      granted_q <= 1'b0;
      on_cnt_q  <= '0;
      off_cnt_q <= '0;
      cap_q     <= '0;
    end else begin
      granted_q <= granted_d;
      on_cnt_q  <= on_cnt_d;
      off_cnt_q <= off_cnt_d;
      cap_q     <= cap_d;
    end
  end

  assign granted_o   = granted_q;
  assign release_o   = release_w;
  assign grantable_o = req_i && !granted_q && (off_cnt_q == '0);
  assign cap_cost_o  = cap_q;

endmodule

// File: rtl/smart_house_load_sched.sv
// Round-robin power-budget scheduler: one load evaluated per cycle, grants kept within BUDGET,
// cooler/heater never on together.
module smart_house_load_sched
  import smart_house_pkg::*;
#(
  parameter int N_LOADS  = N_LOADS_DEF,
  parameter int COST_W   = COST_W_DEF,
  parameter int BUDGET   = BUDGET_DEF,
  parameter int MIN_ON   = MIN_ON_DEF,
  parameter int COOLDOWN = COOLDOWN_DEF,
  parameter int EXCL_A   = LOAD_COOLER,
  parameter int EXCL_B   = LOAD_HEATER
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [N_LOADS-1:0]        req_i,
  input  logic [N_LOADS*COST_W-1:0] cost_i,
  output logic [N_LOADS-1:0]        grant_o,
  output logic [COST_W+2:0]         used_o,
  output logic [N_LOADS-1:0]        reject_o,
  output logic [2:0]                ptr_o
);

  localparam int UW = COST_W + 3;

  logic [2:0]         ptr_q, ptr_d;
  logic [UW-1:0]      used_q, used_d;
  logic [N_LOADS-1:0] reject_q, reject_d;
  logic [N_LOADS-1:0] issue_vec, granted, released, grantable;
  logic [COST_W-1:0]  eff_cost [N_LOADS];
  logic [COST_W-1:0]  cap_cost [N_LOADS];

  logic [COST_W-1:0]  sel_cost;
  logic               sel_grantable, sel_req, excl_ok, fits, issue;
  logic [UW-1:0]      rel_sum;

  for (genvar g = 0; g < N_LOADS; g++) begin : g_slot
    // A zero cost would let a load ride for free; bill it as one unit instead.
    assign eff_cost[g] = (cost_i[g*COST_W +: COST_W] == '0) ? COST_W'(1)
                                                           : cost_i[g*COST_W +: COST_W];

    load_slot #(
      .COST_W  (COST_W),
      .MIN_ON  (MIN_ON),
      .COOLDOWN(COOLDOWN)
    ) u_slot (
      .clock        (clock),
      .reset        (reset),
      .grant_issue_i(issue_vec[g]),
      .cost_i       (eff_cost[g]),
      .req_i        (req_i[g]),
      .granted_o    (granted[g]),
      .release_o    (released[g]),
      .grantable_o  (grantable[g]),
      .cap_cost_o   (cap_cost[g])
    );
  end

  always_comb begin
    sel_cost      = '0;
    sel_grantable = 1'b0;
    sel_req       = 1'b0;
    for (int i = 0; i < N_LOADS; i++) begin
      if (ptr_q == 3'(i)) begin
        sel_cost      = eff_cost[i];
        sel_grantable = grantable[i];
        sel_req       = req_i[i];
      end
    end

    excl_ok = !(((ptr_q == 3'(EXCL_A)) && granted[EXCL_B]) ||
                ((ptr_q == 3'(EXCL_B)) && granted[EXCL_A]));
    // Budget check sees pre-edge used; budget freed this cycle shows up next cycle.
    fits  = (used_q + UW'(sel_cost)) <= UW'(BUDGET);
    issue = sel_grantable && fits && excl_ok;

    issue_vec = '0;
    reject_d  = '0;
    rel_sum   = '0;
    for (int i = 0; i < N_LOADS; i++) begin
      if (ptr_q == 3'(i)) begin
        issue_vec[i] = issue;
        reject_d[i]  = sel_req && (UW'(sel_cost) > UW'(BUDGET));
      end
      if (released[i]) begin
        rel_sum = rel_sum + UW'(cap_cost[i]);
      end
    end

    used_d = used_q + (issue ? UW'(sel_cost) : UW'(0)) - rel_sum;
    ptr_d  = (ptr_q == 3'(N_LOADS - 1)) ? 3'd0 : ptr_q + 3'd1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ptr_q    <= '0;
      used_q   <= '0;
      reject_q <= '0;
    end else begin
      ptr_q    <= ptr_d;
      used_q   <= used_d;
      reject_q <= reject_d;
    end
  end

  assign grant_o  = granted;
  assign used_o   = used_q;
  assign reject_o = reject_q;
  assign ptr_o    = ptr_q;

endmodule

// File: doc/smart_house_load_sched.md
Name: smart_house_load_sched

Overview:
- Power-budget scheduler for house appliances (music, curtain, light, cooler, heater, ...).
- Each appliance controller raises a request with a power cost.
- The block grants loads round-robin so that the summed cost of granted loads never exceeds a budget.
- It enforces minimum on-time, off cool-down and cooler/heater mutual exclusion. It sits between the house mode FSM (requesters) and the appliance drivers (grant = enable).

Parameters:
- N_LOADS, 5, number of requesters (index 0..N_LOADS-1).
- COST_W, 4, bit width of each load cost.
- BUDGET, 8, maximum summed cost of granted loads.
- MIN_ON, 16, cycles a grant is held after issue, regardless of request.
- COOLDOWN, 8, cycles a load is ungrantable after its grant drops.
- EXCL_A, 3, index of first mutually exclusive load (cooler).
- EXCL_B, 4, index of second mutually exclusive load (heater).

Ports:
- clock, input, 1, system clock.
- reset, input, 1, synchronous active-high reset.
- req, input, N_LOADS, level request per load.
- cost, input, N_LOADS*COST_W, packed cost per load; slice i = cost[i*COST_W +: COST_W].
- grant, output, N_LOADS, registered enable per load.
- used, output, COST_W+3, registered sum of captured costs of granted loads.
- reject, output, N_LOADS, one-cycle pulse when an evaluated load's cost exceeds BUDGET.
- ptr, output, 3, current scan index (debug).

Behaviour:
- Reset: synchronous, active-high (reset), clock clock. On reset, at the next edge:
  - grant=0, used=0, reject=0, ptr=0.
  - All on/off counters and captured costs are cleared.
  - Reset mid-operation drops every grant at that edge with no cool-down.
- Scan pointer: ptr advances by 1 every cycle out of reset and wraps N_LOADS-1 -> 0. Exactly one load p=ptr is evaluated per cycle.
- Grant condition for p, evaluated on registered state:
  - req[p]=1 and grant[p]=0 and off_cnt[p]=0;
  - used + cost[p] <= BUDGET, computed at COST_W+3 bits with no overflow;
  - if p is EXCL_A or EXCL_B, the other one is not granted;
  - cost[p] != 0. A cost of 0 is treated as 1.
- On grant, at that edge:
  - grant[p]<=1;
  - cap_cost[p]<=cost[p];
  - on_cnt[p]<=MIN_ON;
  - used<=used+cost[p].
- Grant latency: 1 to N_LOADS cycles after req rises, depending on ptr position.
- Cost overflow: if cost[p] > BUDGET when p is evaluated with req[p]=1, reject[p] pulses for one cycle and no grant is issued. This repeats each visit while the request persists.
- Hold: while grant[i]=1 and on_cnt[i]>0, on_cnt[i] decrements each cycle.
- Release: when grant[i]=1, on_cnt[i]=0 and req[i]=0, at that edge:
  - grant[i]<=0;
  - used<=used-cap_cost[i];
  - off_cnt[i]<=COOLDOWN.
- Multiple releases in one cycle: all take effect at the same edge and used subtracts all of them.
- Cooldown: off_cnt[i] decrements to 0. The load is re-grantable when off_cnt=0.
- Cost change while granted: ignored. used always reflects cap_cost.
- Simultaneous grant and release in one cycle:
  - The grant check uses pre-edge used, so freed budget is visible from the next cycle.
  - used_next = used + granted_cost - sum(released cap_cost).
- Request drop before MIN_ON expires: the grant stays held until on_cnt=0, then is released. A request re-asserted during the hold keeps the grant.
- Invariant: used <= BUDGET and used equals the sum of cap_cost over granted loads, at all times.
- Never grant EXCL_A and EXCL_B together.

Decomposition:
- Shared package smart_house_pkg holds:
  - load index constants: LOAD_MUSIC=0, LOAD_CURTAIN=1, LOAD_LIGHT=2, LOAD_COOLER=3, LOAD_HEATER=4;
  - default costs;
  - MIN_ON and COOLDOWN defaults.
- Sub-module load_slot, instantiated N_LOADS times:
  - state: grant flag, on_cnt, off_cnt, cap_cost;
  - inputs: grant_issue, cost_in, req;
  - outputs: granted, release_pulse, grantable, cap_cost.
- The top level holds the pointer, the budget/exclusion check and the used accumulator.

Test Plan:
- Costs {1,2,1,5,6}, req[0]=1 at ptr=0 -> grant[0]=1 next edge, used=1; req dropped at once -> grant held 16 cycles, then drops, used=0; re-request is not granted for 8 cycles.
- req[3] then req[4] both held, costs 5 and 6 -> only cooler granted (used=5); heater never granted while cooler is on; cooler req dropped plus MIN_ON expiry -> heater granted after ptr reaches 4 and budget allows.
- All req=1 with costs {1,2,1,5,6} -> greedy round-robin grants 0,1,2 (used=4), cooler not (4+5=9>8); used never exceeds 8 in any cycle.
- cost[2]=9 with req[2]=1 -> reject[2] pulses once every N_LOADS cycles, grant[2] stays 0, used unchanged.
- Loads 0 and 1 granted, reset asserted mid-hold -> grant=0, used=0, ptr=0 after one edge; req kept high -> re-granted without cool-down.
- Load 0 releasing in the same cycle that load 1 is evaluated and granted (budget tight, BUDGET=3, costs 2 and 2, load 0 granted) -> load 1 not granted that cycle, granted on its next visit; used transitions 2 -> 0 -> 2.
